// File: rtl/spart_key_rx.sv
// UART 8N1 receiver mapping ASCII keys (w s a d q e r space) to 4-bit codes with a one-cycle strobe.
// Define SPART_PARITY_EN for 8E1 frames with even-parity checking.
module spart_key_rx #(
  parameter int DIVISOR = 434,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       SPART_we,
  output logic [3:0] SPART_keys,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIVISOR - 1);

  logic             sync1_q, rs_q, rs_d_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             we_q, we_d;
  logic [3:0]       keys_q, keys_d;
  logic             par_ok_q, par_ok_d;
  logic             cnt_zero;
  logic [4:0]       dec;

  // {hit, code}; hit=0 for characters that are not keys
  function automatic logic [4:0] key_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'b0_0000;
    case (b)
      8'h77, 8'h57: r = 5'b1_0001;
      8'h73, 8'h53: r = 5'b1_0010;
      8'h61, 8'h41: r = 5'b1_0011;
      8'h64, 8'h44: r = 5'b1_0100;
      8'h71, 8'h51: r = 5'b1_0101;
      8'h65, 8'h45: r = 5'b1_0110;
      8'h72, 8'h52: r = 5'b1_0111;
      8'h20:        r = 5'b1_1000;
      default:      r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rs_q      <= 1'b1;
      rs_d_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      we_q      <= 1'b0;
      keys_q    <= 4'h0;
      par_ok_q  <= 1'b1;
    end else begin
      sync1_q   <= rxd;
      rs_q      <= sync1_q;
      rs_d_q    <= rs_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      we_q      <= we_d;
      keys_q    <= keys_d;
      par_ok_q  <= par_ok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    we_d      = 1'b0;
    keys_d    = keys_q;
    par_ok_d  = par_ok_q;
    cnt_zero  = (cnt_q == '0);
    dec       = key_decode(shift_q);

    case (state_q)
      IDLE: begin
        // edge-triggered so a held-low (break) line cannot retrigger
        if (rs_d_q && !rs_q) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rs_q) begin
          cnt_d     = FULL_LOAD;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d   = {rs_q, shift_q[7:1]};
          cnt_d     = FULL_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef SPART_PARITY_EN
            state_d = PARITY;
`else
            par_ok_d = 1'b1;
            state_d  = STOP;
`endif
          end
        end
      end
`ifdef SPART_PARITY_EN
      PARITY: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_ok_d = ~((^shift_q) ^ rs_q);
          cnt_d    = FULL_LOAD;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          if (rs_q && par_ok_q && dec[4]) begin
            we_d   = 1'b1;
            keys_d = dec[3:0];
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign SPART_we   = we_q;
  assign SPART_keys = keys_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spart_key_rx.sv
// Randomised scoreboard bench for spart_key_rx: frames are modelled at character level and strobes checked by a monitor.
module tb_spart_key_rx;

  localparam int D = 16;
`ifdef SPART_PARITY_EN
  localparam int LAT = 4 + (19 * D) / 2 + D;
`else
  localparam int LAT = 4 + (19 * D) / 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       SPART_we;
  logic [3:0] SPART_keys;
  logic       rx_busy;

  spart_key_rx #(.DIVISOR(D), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .SPART_we   (SPART_we),
    .SPART_keys (SPART_keys),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] key;
    int         fall;
  } exp_t;
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic check_rng(input string name, input int got, input int lo, input int hi);
    n_chk++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, got, lo, hi, cyc);
  endtask

  // Reference: key code of a character, or -1 when it is not a key
  function automatic int model_key(input logic [7:0] b);
    string      keys;
    logic [7:0] c;
    keys = "wsadqer ";
    c = b;
    if (c >= 8'h41 && c <= 8'h5A) c = c + 8'd32;
    for (int i = 0; i < 8; i++)
      if (c == keys[i]) return i + 1;
    return -1;
  endfunction

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; abort_bit >= 0 pulses reset in the middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit par_flip, input int abort_bit);
    int k;
    bit ok;
    k = model_key(b);
`ifdef SPART_PARITY_EN
    ok = stop_v && !par_flip;
`else
    ok = stop_v;
`endif
    @(negedge clk);
    rxd = 1'b0;
    if (ok && k > 0 && abort_bit < 0) exp_q.push_back('{4'(k), cyc});
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == abort_bit) begin
        repeat (D / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_we", SPART_we, 0);
        check("reset_keys", SPART_keys, 0);
        check("reset_busy", rx_busy, 0);
        repeat (3) @(negedge clk);
        rxd   = 1'b1;
        rst_n = 1'b1;
        return;
      end
      repeat (D) @(negedge clk);
    end
`ifdef SPART_PARITY_EN
    rxd = (^b) ^ par_flip;
    repeat (D) @(negedge clk);
`endif
    rxd = stop_v;
    repeat (D) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest expected key
  logic we_prev = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (SPART_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_keys", SPART_keys, e.key);
        check_rng("strobe_latency", cyc - e.fall, LAT - 1, LAT + 1);
      end
      check("strobe_width", we_prev, 0);
      check("busy_at_strobe", rx_busy, 0);
    end
    we_prev = SPART_we;
  end

  initial begin
    string      pool;
    logic [7:0] b;
    bit         sv, pf;
    int         busy_cnt;

    pool = "wsadqerWSADQER ";
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    check("por_we", SPART_we, 0);
    check("por_keys", SPART_keys, 0);
    check("por_busy", rx_busy, 0);
    rst_n = 1'b1;
    idle(5);

    send_frame(8'h77, 1'b1, 1'b0, -1);
    idle(20);
    check("keys_after_w", SPART_keys, 1);

    send_frame(8'h44, 1'b1, 1'b0, -1);
    send_frame(8'h78, 1'b1, 1'b0, -1);
    idle(20);
    check("keys_hold_after_x", SPART_keys, 4);

    // short low glitch must be rejected at the start-bit midpoint
    @(negedge clk);
    rxd = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 4) rxd = 1'b1;
      if (rx_busy) busy_cnt++;
    end
    check_rng("glitch_busy_cycles", busy_cnt, 7, 9);
    check("glitch_keys", SPART_keys, 4);

    send_frame(8'h61, 1'b0, 1'b0, -1);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    check("break_not_busy", rx_busy, 0);
    idle(5);
    send_frame(8'h20, 1'b1, 1'b0, -1);
    idle(20);
    check("keys_after_space", SPART_keys, 8);

    send_frame(8'h71, 1'b1, 1'b0, 3);
    idle(2 * LAT);
    check("keys_after_abort", SPART_keys, 0);
    send_frame(8'h65, 1'b1, 1'b0, -1);
    idle(20);
    check("keys_after_e", SPART_keys, 6);

`ifdef SPART_PARITY_EN
    send_frame(8'h72, 1'b1, 1'b0, -1);
    idle(20);
    check("keys_parity_good", SPART_keys, 7);
    send_frame(8'h77, 1'b1, 1'b1, -1);
    send_frame(8'h72, 1'b1, 1'b1, -1);
    idle(20);
    check("keys_parity_bad", SPART_keys, 7);
`endif

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(9, 0) < 6) b = pool[$urandom_range(14, 0)];
      else b = 8'($urandom);
      sv = ($urandom_range(6, 0) != 0);
`ifdef SPART_PARITY_EN
      pf = ($urandom_range(5, 0) == 0);
`else
      pf = 1'b0;
`endif
      send_frame(b, sv, pf, -1);
      if (sv) idle($urandom_range(10, 0));
      else idle($urandom_range(12, 2));
    end

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
